// File: rtl/subtractor_32to16.sv
//==============================================================================
// Module   : subtractor_32to16
// Brief    : Multi-cycle ripple-borrow subtractor recovering A = sum - B.
// Revision : 1.0
//==============================================================================
`default_nettype none

module subtractor_32to16 #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        count,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] sum,
    input  logic [15:0] B,
    output logic [15:0] A,
    output logic        borrow,
    output logic        error,
    output logic        busy,
    output logic        done
);

    localparam int c_NUM_CHUNKS = 16 / BITS_PER_CYCLE;
    localparam logic [c_NUM_CHUNKS-1:0] c_PTR_FIRST = c_NUM_CHUNKS'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [31:0]               r_sum;
    logic [15:0]               r_b;
    logic                      r_br;
    logic [c_NUM_CHUNKS-1:0]   r_ptr;
    logic [15:0]               r_diff;

    logic                      w_accept;
    logic                      w_last;
    logic [c_NUM_CHUNKS-1:0]   w_ptr_shift;
    logic [BITS_PER_CYCLE-1:0] w_s_chunk;
    logic [BITS_PER_CYCLE-1:0] w_b_chunk;
    logic [BITS_PER_CYCLE-1:0] w_d_chunk;
    logic                      w_br_out;
    logic [15:0]               w_diff_merged;
    logic                      w_error;

    assign w_last = r_ptr[c_NUM_CHUNKS-1];

    // A single-chunk configuration has nothing to shift towards.
    generate
        if (c_NUM_CHUNKS == 1) begin : g_ptr_single
            assign w_ptr_shift = r_ptr;
        end else begin : g_ptr_multi
            assign w_ptr_shift = {r_ptr[c_NUM_CHUNKS-2:0], 1'b0};
        end
    endgenerate

    // Select the active chunk, ripple the borrow through it, merge the result.
    always_comb begin
        logic w_br;
        w_s_chunk     = '0;
        w_b_chunk     = '0;
        w_d_chunk     = '0;
        w_diff_merged = r_diff;
        for (int k = 0; k < c_NUM_CHUNKS; k++) begin
            if (r_ptr[k]) begin
                w_s_chunk = w_s_chunk | r_sum[k*BITS_PER_CYCLE +: BITS_PER_CYCLE];
                w_b_chunk = w_b_chunk | r_b[k*BITS_PER_CYCLE +: BITS_PER_CYCLE];
            end
        end
        w_br = r_br;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_d_chunk[i] = w_s_chunk[i] ^ w_b_chunk[i] ^ w_br;
            w_br = (~w_s_chunk[i] & w_b_chunk[i]) | (~w_s_chunk[i] & w_br) |
                   (w_b_chunk[i] & w_br);
        end
        w_br_out = w_br;
        for (int k = 0; k < c_NUM_CHUNKS; k++) begin
            if (r_ptr[k]) begin
                w_diff_merged[k*BITS_PER_CYCLE +: BITS_PER_CYCLE] = w_d_chunk;
            end
        end
        w_error = (r_sum[31:17] != 15'd0) | (r_sum[16] ^ w_br_out);
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = start;
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_accept     = start;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge count) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sum   <= '0;
            r_b     <= '0;
            r_br    <= 1'b0;
            r_ptr   <= '0;
            r_diff  <= '0;
            A       <= '0;
            borrow  <= 1'b0;
            error   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_sum  <= sum;
                r_b    <= B;
                r_br   <= 1'b0;
                r_ptr  <= c_PTR_FIRST;
                r_diff <= '0;
            end else if (r_state == S_RUN) begin
                r_br   <= w_br_out;
                r_ptr  <= w_ptr_shift;
                r_diff <= w_diff_merged;
                if (w_last) begin
                    A      <= w_diff_merged;
                    borrow <= w_br_out;
                    error  <= w_error;
                end
            end
        end
    end

endmodule

`default_nettype wire
